wb_arb2: RTL and testbench

Two-master, one-slave Wishbone arbiter that shares the single on-chip RAM slave between the CPU instruction-fetch port (master 0) and data port (master 1). It sits between the CPU bus ports and the RAM port of the interconnect. Arbitration is round-robin, and a grant is held for the whole `cyc` cycle of the winning master. A bus-timeout watchdog terminates any access the slave fails to acknowledge, so neither master can hang.

---
 rtl/wb_arb2.sv | 155 +++++++++++++++
 tb/tb_wb_arb2.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2.sv
// wb_arb2: round-robin arbiter sharing one Wishbone slave between two masters.
// Ports: clk, rst_n; m0_*/m1_* master ports; s_* slave port; gnt_o grant; tmo_o timeout pulse.
module wb_arb2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,

    output logic [1:0]      gnt_o,
    output logic            tmo_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        GNT0,
        GNT1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            last;
    logic            last_nx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;

    // Owner-side view of the bus, muxed by the current grant.
    logic            own1;
    logic            busy;
    logic            o_cyc;
    logic            o_stb;
    logic            x_cyc;
    logic            tmo;

    assign own1  = (state == GNT1);
    assign busy  = (state != IDLE);
    assign o_cyc = own1 ? m1_cyc_i : m0_cyc_i;
    assign o_stb = (own1 ? m1_stb_i : m0_stb_i) & o_cyc;
    assign x_cyc = own1 ? m0_cyc_i : m1_cyc_i;

    // Ack/err in the same cycle wins over the watchdog.
    assign tmo = busy && o_stb && (cnt == CW'(TIMEOUT - 1))
                 && !s_ack_i && !s_err_i;

    assign tmo_o    = tmo;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        cnt_nx   = '0;
        unique case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_nx = last ? GNT0 : GNT1;
                else if (m0_cyc_i)
                    state_nx = GNT0;
                else if (m1_cyc_i)
                    state_nx = GNT1;
            end
            GNT0, GNT1: begin
                if (!o_cyc) begin
                    last_nx  = own1;
                    if (x_cyc)
                        state_nx = own1 ? GNT0 : GNT1;
                    else
                        state_nx = IDLE;
                end else if (o_stb && !s_ack_i && !s_err_i && !tmo) begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = 2'b00;
        if (busy) begin
            // cyc stays up through a handover cycle so the slave sees
            // one continuous bus cycle when the other master is waiting.
            s_cyc_o = m0_cyc_i | m1_cyc_i;
            s_stb_o = o_stb;
            s_we_o  = own1 ? m1_we_i  : m0_we_i;
            s_sel_o = own1 ? m1_sel_i : m0_sel_i;
            s_adr_o = own1 ? m1_adr_i : m0_adr_i;
            s_dat_o = own1 ? m1_dat_i : m0_dat_i;
            if (own1) begin
                gnt_o    = 2'b10;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | tmo;
            end else begin
                gnt_o    = 2'b01;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | tmo;
            end
        end
    end

endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: directed scenarios plus a randomized run against a
// cycle-level arbitration model for wb_arb2 with TIMEOUT=8.
module tb_wb_arb2;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [SW-1:0] m0_sel_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i, m0_dat_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [SW-1:0] m1_sel_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i, m1_dat_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [SW-1:0] s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic          s_ack_i, s_err_i;
    logic [1:0]    gnt_o;
    logic          tmo_o;

    int checks = 0;
    int errors = 0;

    wb_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o), .tmo_o(tmo_o)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        m0_sel_i = '0; m0_adr_i = '0; m0_dat_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        m1_sel_i = '0; m1_adr_i = '0; m1_dat_i = '0;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset;
        logic [8:0] ctl;
        idle_inputs();
        rst_n = 0;
        s_dat_i = 32'h1234_5678;
        #2;
        ctl = {s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m0_err_o,
               m1_ack_o, m1_err_o, tmo_o, |gnt_o};
        checks++;
        if (ctl !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp %b", ctl, 9'b0);
        end
        checks++;
        if ({s_sel_o, s_adr_o, s_dat_o} !== '0) begin
            errors++;
            $display("FAIL reset_bus got %h exp 0",
                     {s_sel_o, s_adr_o, s_dat_o});
        end
        checks++;
        if (m0_dat_o !== 32'h1234_5678 || m1_dat_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_dat got %h/%h exp 12345678",
                     m0_dat_o, m1_dat_o);
        end
        apply_reset();
    endtask

    task automatic test_single_read;
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100; m0_sel_i = 4'hF;
        step();
        checks++;
        if (gnt_o !== 2'b01 || s_stb_o !== 1'b1 || s_adr_o !== 32'h100) begin
            errors++;
            $display("FAIL single_gnt got gnt=%b stb=%b adr=%h exp 01/1/100",
                     gnt_o, s_stb_o, s_adr_o);
        end
        step();
        s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'hDEAD_BEEF || m1_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL single_ack got ack0=%b dat=%h ack1=%b exp 1/deadbeef/0",
                     m0_ack_o, m0_dat_o, m1_ack_o);
        end
        step();
        idle_inputs();
        step();
        checks++;
        if (gnt_o !== 2'b00) begin
            errors++;
            $display("FAIL single_idle got %b exp 00", gnt_o);
        end
    endtask

    task automatic test_simultaneous;
        logic [1:0] seq [4];
        apply_reset();
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        seq[0] = gnt_o;
        s_ack_i = 1;
        #1;
        checks++;
        if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL simul_ack0 got %b%b exp 01", m1_ack_o, m0_ack_o);
        end
        step();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        #1;
        checks++;
        if (s_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL simul_handover_cyc got %b exp 1", s_cyc_o);
        end
        step();
        seq[1] = gnt_o;
        s_ack_i = 1;
        #1;
        checks++;
        if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL simul_ack1 got %b%b exp 10", m1_ack_o, m0_ack_o);
        end
        step();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step();
        seq[2] = gnt_o;
        checks++;
        if ({seq[0], seq[1], seq[2]} !== 6'b01_10_00) begin
            errors++;
            $display("FAIL simul_order got %b %b %b exp 01 10 00",
                     seq[0], seq[1], seq[2]);
        end
        // m0 serves alone, so it becomes the most recent owner.
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        s_ack_i = 1;
        step();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        step();
        seq[3] = gnt_o;
        checks++;
        if (seq[3] !== 2'b10) begin
            errors++;
            $display("FAIL simul_rr got %b exp 10", seq[3]);
        end
        s_ack_i = 1;
        step();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        step();
        step();
        checks++;
        if (gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL simul_rr_next got %b exp 01", gnt_o);
        end
        s_ack_i = 1;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_no_preempt;
        int writes = 0;
        int held = 0;
        m1_cyc_i = 1; m1_we_i = 1; m1_sel_i = 4'hF;
        step();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h40;
        for (int b = 0; b < 8; b++) begin
            m1_stb_i = (b % 2 == 0);
            m1_adr_i = 32'h300 + 32'(b / 2) * 4;
            m1_dat_i = $urandom;
            s_ack_i = m1_stb_i;
            #1;
            if (gnt_o == 2'b10) held++;
            if (m1_stb_i && s_stb_o && s_we_o && s_sel_o == 4'hF &&
                s_adr_o == m1_adr_i && s_dat_o == m1_dat_i && m1_ack_o)
                writes++;
            step();
        end
        checks++;
        if (held !== 8) begin
            errors++;
            $display("FAIL nopre_hold got %0d exp 8", held);
        end
        checks++;
        if (writes !== 4) begin
            errors++;
            $display("FAIL nopre_writes got %0d exp 4", writes);
        end
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; s_ack_i = 0;
        step();
        checks++;
        if (gnt_o !== 2'b01 || s_adr_o !== 32'h40) begin
            errors++;
            $display("FAIL nopre_next got %b/%h exp 01/40", gnt_o, s_adr_o);
        end
        s_ack_i = 1;
        step();
        idle_inputs();
        step();
    endtask

    task automatic test_timeout(input bit collide);
        int pulses = 0;
        int bad = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h200;
        step();
        for (int k = 1; k <= 10; k++) begin
            s_ack_i = collide && (k == TMO);
            #1;
            if (tmo_o) pulses++;
            if (collide) begin
                if (m0_err_o || tmo_o || m0_ack_o !== (k == TMO)) bad++;
            end else begin
                if (m0_err_o !== (k == TMO) || tmo_o !== (k == TMO) || m0_ack_o)
                    bad++;
            end
            step();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s got %0d bad cycles exp 0",
                     collide ? "tmo_collide" : "tmo_fire", bad);
        end
        checks++;
        if (pulses !== (collide ? 0 : 1)) begin
            errors++;
            $display("FAIL tmo_pulses got %0d exp %0d", pulses, collide ? 0 : 1);
        end
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_reset_mid;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h500;
        step();
        checks++;
        if (gnt_o !== 2'b10) begin
            errors++;
            $display("FAIL rmid_gnt got %b exp 10", gnt_o);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({s_cyc_o, s_stb_o, gnt_o} !== 4'b0) begin
            errors++;
            $display("FAIL rmid_drop got %b exp 0000",
                     {s_cyc_o, s_stb_o, gnt_o});
        end
        idle_inputs();
        #1;
        rst_n = 1;
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        checks++;
        if (gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL rmid_regrant got %b exp 01", gnt_o);
        end
        idle_inputs();
        step();
        step();
    endtask

    // Randomized traffic: each master runs bursts of 1..3 accesses,
    // the slave acks, errs or goes silent at random.
    task automatic test_random;
        int own, lst, waitc, dead, r;
        int nacc [2];
        bit hold [2];
        logic [1:0] cyc, stb, we;
        logic [AW-1:0] adr [2];
        logic ack, err, se, tm, term;
        logic [7:0] exp_v, got_v;
        logic [AW-1:0] exp_a;
        apply_reset();
        own = -1; lst = 1; waitc = 0; dead = 0;
        cyc = 0; stb = 0; we = 0;
        nacc[0] = 0; nacc[1] = 0; hold[0] = 0; hold[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!cyc[m] && !hold[m] && $urandom_range(0, 3) == 0) begin
                    cyc[m] = 1;
                    nacc[m] = int'($urandom_range(1, 3));
                end
                hold[m] = 0;
                stb[m] = cyc[m] && ($urandom_range(0, 3) != 0);
                we[m]  = cyc[m] && $urandom_range(0, 1) == 1;
                adr[m] = $urandom;
            end
            se = (own >= 0) && cyc[own] && stb[own];
            ack = 0; err = 0;
            if (dead > 0) begin
                dead--;
            end else begin
                r = int'($urandom_range(0, 31));
                ack = se && r < 12;
                err = se && r == 12;
                if (r == 31) dead = 12;
            end
            m0_cyc_i = cyc[0]; m0_stb_i = stb[0]; m0_we_i = we[0];
            m0_adr_i = adr[0]; m0_sel_i = 4'hF; m0_dat_i = $urandom;
            m1_cyc_i = cyc[1]; m1_stb_i = stb[1]; m1_we_i = we[1];
            m1_adr_i = adr[1]; m1_sel_i = 4'h3; m1_dat_i = $urandom;
            s_ack_i = ack; s_err_i = err; s_dat_i = $urandom;
            #1;
            tm = se && waitc == TMO - 1 && !ack && !err;
            exp_v = '0;
            if (own >= 0) begin
                exp_v[7:6] = (own == 1) ? 2'b10 : 2'b01;
                exp_v[5] = cyc[0] | cyc[1];
                exp_v[4] = se;
                exp_v[3] = we[own];
                if (own == 0) exp_v[2:1] = {ack, err | tm};
                else          exp_v[1:0] = {ack, err | tm};
                exp_v[0] = (own == 1) ? (err | tm) : 1'b0;
                exp_v[1] = (own == 1) ? ack : (err | tm);
                exp_v[2] = (own == 0) ? ack : 1'b0;
            end
            exp_a = (own >= 0) ? adr[own] : '0;
            got_v = {gnt_o, s_cyc_o, s_stb_o, s_we_o,
                     m0_ack_o, m0_err_o | m1_ack_o, m1_err_o};
            checks++;
            if (got_v !== exp_v || tmo_o !== tm) begin
                errors++;
                $display("FAIL rand_ctl c=%0d got %b tmo=%b exp %b tmo=%b",
                         c, got_v, tmo_o, exp_v, tm);
            end
            checks++;
            if (s_adr_o !== exp_a) begin
                errors++;
                $display("FAIL rand_adr c=%0d got %h exp %h", c, s_adr_o, exp_a);
            end
            @(posedge clk);
            if (own < 0) begin
                if (cyc[0] && cyc[1]) own = 1 - lst;
                else if (cyc[0])      own = 0;
                else if (cyc[1])      own = 1;
                waitc = 0;
            end else if (!cyc[own]) begin
                lst = own;
                own = cyc[1 - own] ? 1 - own : -1;
                waitc = 0;
            end else begin
                term = ack | err | tm;
                waitc = (se && !term) ? waitc + 1 : 0;
                if (term) begin
                    nacc[own]--;
                    if (nacc[own] == 0) begin
                        cyc[own] = 0;
                        hold[own] = 1;
                    end
                end
            end
            #1;
        end
        idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_no_preempt();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
